// File: rtl/matrix_result_drain.sv
// rtl/matrix_result_drain.sv - captures an accumulator word and streams it out LSB lane first
// over a byte-wide valid/ready link, optionally pulsing the accumulator clear.
module matrix_result_drain #(
   parameter int DATA_WIDTH = 64,
   parameter int BYTE_WIDTH = 8
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic                  i_clear_after,
   input  logic [DATA_WIDTH-1:0] i_acc_in,
   output logic                  o_acc_clear,
   output logic [BYTE_WIDTH-1:0] o_byte_out,
   output logic                  o_byte_valid,
   input  logic                  i_byte_ready,
   output logic                  o_last,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
   localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_shadow;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_clr_pend;
   logic                  w_accept;

   assign w_accept = (r_state == S_SEND) && i_byte_ready;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_shadow   <= '0;
         r_idx      <= '0;
         r_clr_pend <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_shadow   <= i_acc_in;
                  r_idx      <= '0;
                  r_clr_pend <= i_clear_after;
                  r_state    <= S_SEND;
               end
            end
            S_SEND: begin
               // Clear request lives only for the first SEND cycle.
               r_clr_pend <= 1'b0;
               if (w_accept) begin
                  r_shadow <= r_shadow >> BYTE_WIDTH;
                  r_idx    <= r_idx + IDX_W'(1);
                  if (r_idx == LAST_IDX) begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs decode from registered state only; byte_ready never reaches them.
   assign o_byte_valid = (r_state == S_SEND);
   assign o_busy       = (r_state == S_SEND);
   assign o_byte_out   = r_shadow[BYTE_WIDTH-1:0];
   assign o_last       = (r_state == S_SEND) && (r_idx == LAST_IDX);
   assign o_acc_clear  = (r_state == S_SEND) && r_clr_pend;
   assign o_done       = (r_state == S_DONE);

endmodule

// File: tb/tb_matrix_result_drain.sv
// tb/tb_matrix_result_drain.sv - randomized self-checking bench for matrix_result_drain
// against a lane-queue reference model.
module tb_matrix_result_drain;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_start;
   logic        i_clear_after;
   logic [63:0] i_acc_in;
   logic        o_acc_clear;
   logic [7:0]  o_byte_out;
   logic        o_byte_valid;
   logic        i_byte_ready;
   logic        o_last;
   logic        o_busy;
   logic        o_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   matrix_result_drain #(.DATA_WIDTH(64), .BYTE_WIDTH(8)) dut (
      .i_clock      (clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_clear_after(i_clear_after),
      .i_acc_in     (i_acc_in),
      .o_acc_clear  (o_acc_clear),
      .o_byte_out   (o_byte_out),
      .o_byte_valid (o_byte_valid),
      .i_byte_ready (i_byte_ready),
      .o_last       (o_last),
      .o_busy       (o_busy),
      .o_done       (o_done)
   );

   // Lane queue model: a drain is the eight bytes of the captured word, LSB first,
   // each retired by one handshake, followed by a single done cycle.
   // rmode: 0 ready always high, 1 fixed 0,1,0,0,1 pattern, 2 random.
   task automatic drain(input logic [63:0] word, input logic clr, input int rmode,
                        input logic mutate, input logic spam,
                        output int hs, output int clears, output int cycles);
      logic [7:0] q[$];
      logic       done_pend;
      logic       first;
      logic       rdy;
      logic       exp_valid;
      logic       exp_last;
      logic       exp_done;
      logic       exp_clear;
      int         pat_i;
      int         pat[5];
      pat = '{0, 1, 0, 0, 1};
      pat_i = 0;
      done_pend = 1'b0;
      first = 1'b1;
      hs = 0;
      clears = 0;
      cycles = 0;
      for (int i = 0; i < 8; i++) q.push_back(word[8*i +: 8]);
      i_acc_in = word;
      i_clear_after = clr;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      i_clear_after = 1'($urandom);
      while ((q.size() > 0 || done_pend) && cycles < 200) begin
         cycles++;
         exp_valid = (q.size() > 0);
         exp_last  = (q.size() == 1);
         exp_done  = !exp_valid && done_pend;
         exp_clear = first && clr;
         total++;
         if ({o_byte_valid, o_busy, o_last, o_done, o_acc_clear} !==
             {exp_valid, exp_valid, exp_last, exp_done, exp_clear}) begin
            bad++;
            $display("FAIL drain_ctrl cyc=%0d: got v/b/l/d/c=%b required %b", cycles,
                     {o_byte_valid, o_busy, o_last, o_done, o_acc_clear},
                     {exp_valid, exp_valid, exp_last, exp_done, exp_clear});
         end
         if (exp_valid) begin
            total++;
            if (o_byte_out !== q[0]) begin
               bad++;
               $display("FAIL drain_byte cyc=%0d: got %h required %h", cycles, o_byte_out, q[0]);
            end
         end
         if (o_acc_clear === 1'b1) clears++;
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = 1'(pat[pat_i % 5]);
            default: rdy = 1'($urandom);
         endcase
         pat_i++;
         i_byte_ready = rdy;
         if (mutate) i_acc_in = {$urandom, $urandom};
         if (spam) i_start = 1'($urandom);
         @(posedge clk); #1;
         if (exp_valid && rdy) begin
            void'(q.pop_front());
            hs++;
            if (q.size() == 0) done_pend = 1'b1;
         end else if (exp_done) begin
            done_pend = 1'b0;
         end
         first = 1'b0;
      end
      i_start = 1'b0;
      total++;
      if (cycles >= 200) begin
         bad++;
         $display("FAIL drain_timeout: got %0d cycles required under 200", cycles);
      end
      total++;
      if ({o_byte_valid, o_busy, o_last, o_done, o_acc_clear} !== 5'b0) begin
         bad++;
         $display("FAIL drain_idle: got %b required 00000",
                  {o_byte_valid, o_busy, o_last, o_done, o_acc_clear});
      end
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      i_start = 1'b1;
      i_clear_after = 1'b1;
      i_acc_in = 64'hFFFF_FFFF_FFFF_FFFF;
      i_byte_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({o_acc_clear, o_byte_out, o_byte_valid, o_last, o_busy, o_done} !== 13'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b required all zero",
                  {o_acc_clear, o_byte_out, o_byte_valid, o_last, o_busy, o_done});
      end
      i_start = 1'b0;
      i_reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int hs, clears, cyc;
      drain(64'h0807060504030201, 1'b0, 0, 1'b0, 1'b0, hs, clears, cyc);
      total++;
      if (hs !== 8 || clears !== 0 || cyc !== 9) begin
         bad++;
         $display("FAIL basic_counts: got hs=%0d clr=%0d cyc=%0d required 8 0 9", hs, clears, cyc);
      end
   endtask

   task automatic test_clear_pulse();
      int hs, clears, cyc;
      drain(64'h0807060504030201, 1'b1, 0, 1'b0, 1'b0, hs, clears, cyc);
      total++;
      if (hs !== 8 || clears !== 1 || cyc !== 9) begin
         bad++;
         $display("FAIL clear_counts: got hs=%0d clr=%0d cyc=%0d required 8 1 9", hs, clears, cyc);
      end
   endtask

   task automatic test_backpressure();
      int hs, clears, cyc;
      drain(64'hDEADBEEFCAFEF00D, 1'b0, 1, 1'b0, 1'b0, hs, clears, cyc);
      total++;
      if (hs !== 8 || clears !== 0) begin
         bad++;
         $display("FAIL bp_pattern: got hs=%0d clr=%0d required 8 0", hs, clears);
      end
      for (int k = 0; k < 4; k++) begin
         drain({$urandom, $urandom}, 1'($urandom), 2, 1'b0, 1'b0, hs, clears, cyc);
         total++;
         if (hs !== 8) begin
            bad++;
            $display("FAIL bp_random: got hs=%0d required 8", hs);
         end
      end
   endtask

   task automatic test_capture_isolation();
      int hs, clears, cyc;
      for (int k = 0; k < 4; k++) begin
         drain({$urandom, $urandom}, 1'($urandom), 2, 1'b1, 1'b1, hs, clears, cyc);
         total++;
         if (hs !== 8) begin
            bad++;
            $display("FAIL iso_handshakes: got %0d required 8", hs);
         end
         // No queued request may surface after the drain.
         for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if (o_byte_valid !== 1'b0 || o_done !== 1'b0) begin
               bad++;
               $display("FAIL iso_no_restart: got v=%b d=%b required 0 0", o_byte_valid, o_done);
            end
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      logic [63:0] w;
      int hs, clears, cyc;
      w = {$urandom, $urandom};
      i_acc_in = w;
      i_clear_after = 1'b1;
      i_start = 1'b1;
      i_byte_ready = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (o_byte_valid !== 1'b1 || o_byte_out !== w[8*k +: 8]) begin
            bad++;
            $display("FAIL rst_pre_lane%0d: got v=%b %h required 1 %h", k, o_byte_valid,
                     o_byte_out, w[8*k +: 8]);
         end
         @(posedge clk); #1;
      end
      i_reset = 1'b1;
      @(posedge clk); #1;
      i_reset = 1'b0;
      total++;
      if ({o_acc_clear, o_byte_out, o_byte_valid, o_last, o_busy, o_done} !== 13'b0) begin
         bad++;
         $display("FAIL rst_abort_outputs: got %b required all zero",
                  {o_acc_clear, o_byte_out, o_byte_valid, o_last, o_busy, o_done});
      end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         total++;
         if ({o_acc_clear, o_byte_valid, o_done} !== 3'b0) begin
            bad++;
            $display("FAIL rst_quiet: got c/v/d=%b required 000", {o_acc_clear, o_byte_valid, o_done});
         end
      end
      drain({$urandom, $urandom}, 1'b0, 0, 1'b0, 1'b0, hs, clears, cyc);
      total++;
      if (hs !== 8 || cyc !== 9) begin
         bad++;
         $display("FAIL rst_redrain: got hs=%0d cyc=%0d required 8 9", hs, cyc);
      end
   endtask

   task automatic test_back_to_back();
      int hs, clears, cyc;
      drain({$urandom, $urandom}, 1'b1, 0, 1'b0, 1'b0, hs, clears, cyc);
      total++;
      if (hs !== 8 || cyc !== 9) begin
         bad++;
         $display("FAIL b2b_first: got hs=%0d cyc=%0d required 8 9", hs, cyc);
      end
      drain({$urandom, $urandom}, 1'b1, 0, 1'b0, 1'b0, hs, clears, cyc);
      total++;
      if (hs !== 8 || clears !== 1 || cyc !== 9) begin
         bad++;
         $display("FAIL b2b_second: got hs=%0d clr=%0d cyc=%0d required 8 1 9", hs, clears, cyc);
      end
   endtask

   initial begin
      i_reset = 1'b1;
      i_start = 1'b0;
      i_clear_after = 1'b0;
      i_acc_in = '0;
      i_byte_ready = 1'b0;
      test_reset();
      test_basic();
      test_clear_pulse();
      test_backpressure();
      test_capture_isolation();
      test_reset_mid_drain();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/matrix_result_drain.md
# matrix_result_drain

Read-side counterpart of the matrix accumulate unit: on request it captures the 64-bit accumulated result and streams it out one byte per accepted transfer over an 8-bit valid/ready interface. It sits between the accumulator output and the chip's 8-bit output pins. Optionally it pulses the accumulator's clear so that the next accumulation starts from zero.

## Interface

- DATA_WIDTH, 64, width of the captured accumulator word; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, width of one output transfer
- LANES, DATA_WIDTH/BYTE_WIDTH (8), derived; number of transfers per drain

- clock  in  1  single clock; all logic on its rising edge
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is high
- start  in  1  drain request; sampled only in IDLE
- clear_after  in  1  sampled together with start; 1 means pulse acc_clear after capture
- acc_in  in  DATA_WIDTH  accumulator output word
- acc_clear  out  1  one-cycle clear pulse to the accumulator
- byte_out  out  BYTE_WIDTH  current lane, LSB lane first
- byte_valid  out  1  byte_out holds a valid lane
- byte_ready  in  1  downstream accepts byte_out on a cycle where byte_valid=1
- last  out  1  high with the final lane (lane LANES-1)
- busy  out  1  high in SEND
- done  out  1  one-cycle pulse after the final lane is accepted

## Operation

- States: IDLE, SEND, DONE. The reset state is IDLE.
- IDLE:
  - Outputs idle; busy=0.
  - On start=1: shadow <= acc_in, idx <= 0, clr_pend <= clear_after, next state SEND.
- SEND:
  - byte_valid=1, byte_out=shadow[BYTE_WIDTH-1:0], busy=1.
  - last=1 when idx==LANES-1.
  - acc_clear=1 only in the first SEND cycle, and only if clr_pend=1; clr_pend then drops.
  - On byte_valid && byte_ready:
    - shadow shifts right by BYTE_WIDTH, with zero fill.
    - idx increments.
    - If idx==LANES-1, next state is DONE.
  - Without ready: byte_out, last and idx hold unchanged.
- DONE: done=1 for exactly one cycle; busy=0; byte_valid=0; next state IDLE.
- The captured word is frozen in shadow. Changes on acc_in after the capture cycle never affect the streamed bytes.
- start is ignored in SEND and DONE; requests are not queued.
- byte_ready is ignored whenever byte_valid=0.
- idx is $clog2(LANES) bits wide. Its increment at LANES-1 coincides with leaving SEND, so idx never wraps inside SEND.
- All outputs are registered or decoded directly from state, idx and shadow. There is no combinational path from byte_ready to byte_valid or byte_out.

## Timing

- Reset values: acc_clear=0, byte_out=0, byte_valid=0, last=0, busy=0, done=0; state IDLE, shadow=0, idx=0.
- Reset asserted mid-drain aborts the drain:
  - Next cycle is IDLE with all outputs at reset values.
  - No acc_clear and no done are produced for the aborted drain.
- start=1 in IDLE at cycle N:
  - Capture of acc_in happens at edge N.
  - Cycle N+1: byte_valid=1, byte_out=lane 0; acc_clear=1 in this cycle if clear_after was 1.
- Each accepted handshake advances one lane on the next cycle.
- With byte_ready held high:
  - Lanes 0..7 appear in cycles N+1..N+8; last=1 in N+8.
  - done=1 in N+9; IDLE again in N+10.
  - Minimum start-to-start spacing is 10 cycles.
- Backpressure inserts whole stall cycles; no lane is ever dropped or duplicated.
- The accumulator clears on the edge ending cycle N+1. A start and an accumulator update in the same cycle N capture the pre-update acc_in.

## Test plan

- Basic drain: reset; acc_in=64'h0807060504030201; start=1 with clear_after=0; byte_ready=1 constantly -> bytes 01,02,...,08 in cycles N+1..N+8; last only with 08; done in N+9; acc_clear never asserts.
- Clear pulse: as above with clear_after=1 -> acc_clear=1 only in cycle N+1 and 0 in all other cycles.
- Backpressure: acc_in=64'hDEADBEEFCAFEF00D; byte_ready toggles 0,1,0,0,1,... -> sequence 0D,F0,FE,CA,EF,BE,AD,DE; byte_out stable during every ready=0 cycle; exactly 8 handshakes.
- Capture isolation and start filtering:
  - Change acc_in every cycle after capture -> streamed bytes match the value captured at cycle N.
  - Pulse start during SEND and DONE -> no restart and no extra drain.
- Reset mid-drain: assert reset after the 3rd accepted byte -> next cycle all outputs are 0, state IDLE, no done pulse; a new start then drains lane 0 of the new acc_in.
- Back-to-back: assert start in the first IDLE cycle after done (N+10) with a new word -> second stream begins at N+11 with its lane 0.
